// File: rtl/demux_1x4_nbit_if.sv
// Bus bundle for the 1-to-4 demultiplexer: one producer-side stream and four
// consumer-side channels, each with its own valid/ready pair.
interface demux_1x4_nbit_if #(
    parameter int n = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] w;
    logic [1:0]   s;
    logic         mode;
    logic [n-1:0] f0;
    logic [n-1:0] f1;
    logic [n-1:0] f2;
    logic [n-1:0] f3;
    logic         v0;
    logic         v1;
    logic         v2;
    logic         v3;
    logic         r0;
    logic         r1;
    logic         r2;
    logic         r3;

    modport slave (
        input  in_valid, w, s, mode, r0, r1, r2, r3,
        output in_ready, f0, f1, f2, f3, v0, v1, v2, v3
    );

    modport master (
        output in_valid, w, s, mode, r0, r1, r2, r3,
        input  in_ready, f0, f1, f2, f3, v0, v1, v2, v3
    );
endinterface

// File: rtl/demux_1x4_nbit.sv
// Registered 1-to-4 demultiplexer: steers one valid/ready stream into four
// single-word output registers, by explicit select or by round-robin pointer.
module demux_1x4_nbit #(
    parameter int n = 4
) (
    input logic             clk,
    input logic             rst_n,
    demux_1x4_nbit_if.slave bus
);

    logic [n-1:0] f_q [4];
    logic [3:0]   v_q;
    logic [1:0]   ptr_q;

    logic [3:0]   r_vec;
    logic [1:0]   t;
    logic         in_ready;
    logic         accept;
    logic [3:0]   load;

    assign r_vec = {bus.r3, bus.r2, bus.r1, bus.r0};

    // A full target that drains this cycle still has room for the new word.
    always_comb begin
        t        = bus.mode ? ptr_q : bus.s;
        in_ready = rst_n & (~v_q[t] | r_vec[t]);
        accept   = bus.in_valid & in_ready;
        load     = 4'b0000;
        if (accept) begin
            load[t] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                f_q[k] <= '0;
            end
            v_q   <= 4'b0000;
            ptr_q <= 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    f_q[k] <= bus.w;
                    v_q[k] <= 1'b1;
                end else if (v_q[k] && r_vec[k]) begin
                    v_q[k] <= 1'b0;
                end
            end
            if (accept && bus.mode) begin
                ptr_q <= ptr_q + 2'd1;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.f0       = f_q[0];
    assign bus.f1       = f_q[1];
    assign bus.f2       = f_q[2];
    assign bus.f3       = f_q[3];
    assign bus.v0       = v_q[0];
    assign bus.v1       = v_q[1];
    assign bus.v2       = v_q[2];
    assign bus.v3       = v_q[3];

endmodule

// File: doc/demux_1x4_nbit.md
# demux_1x4_nbit

Registered 1-to-4 n-bit demultiplexer with valid/ready handshakes: the distributing counterpart of the 4x1 n-bit mux. A single input stream is steered to one of four output channels, either by an explicit select or by an internal round-robin pointer. Each channel holds one word in an output register until its consumer accepts it. The block sits between one producer and four consumers that drain at independent rates.

## Interface
- `n`, default 4: data width in bits.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the input word this cycle.
- `w`  in  n  input data.
- `s`  in  2  channel select, used when `mode`=0.
- `mode`  in  1  routing mode: 0 = explicit select `s`, 1 = round-robin pointer.
- `f0`, `f1`, `f2`, `f3`  out  n each  channel output data registers.
- `v0`, `v1`, `v2`, `v3`  out  1 each  channel output valid.
- `r0`, `r1`, `r2`, `r3`  in  1 each  channel consumer ready.

## Operation
- **State**
  - Four data registers `f0`..`f3`.
  - Four valid flags `v0`..`v3`.
  - 2-bit round-robin pointer `ptr`.
- **Target channel** `t` is combinational: `t = mode ? ptr : s`.
- **Input ready**
  - `in_ready = rst_n & (!v[t] | r[t])`.
  - A full target that is draining in the same cycle still accepts.
- **Accept** = `in_valid & in_ready`. On accept, at the clock edge:
  - `f[t] <= w`
  - `v[t] <= 1`
- **Channel k drain**: when `vk & rk` and channel k is not loaded in the same cycle, `vk <= 0`.
- **Simultaneous drain and load** on the same channel: `vk` stays 1 and `fk` takes the new word.
- **Data hold**: `fk` holds its value whenever the channel is not loaded, including after a drain. Consumers qualify `fk` with `vk`.
- **Channel independence**: channels not equal to `t` keep draining regardless of input activity.
- **Round-robin pointer**
  - In `mode`=1, `ptr` increments by 1 modulo 4 on each accept (3 wraps to 0).
  - With no accept, `ptr` holds.
  - In `mode`=0, `ptr` holds and `s` routes the data.
- **Mode switching** takes effect in the same cycle, because `t` is combinational. `ptr` keeps its value across mode changes.
- **Upstream protocol**: the producer holds `w`, `s` and `in_valid` stable until accepted. The block does not check this.
- **Blocking**: a full target channel with its ready low blocks the input (`in_ready`=0). Other channels are unaffected.

## Timing
- **Reset**: `rst_n` low at a rising edge sets:
  - `f0`..`f3` = 0
  - `v0`..`v3` = 0
  - `ptr` = 0
- **Reset effects**
  - Held words are discarded.
  - `in_ready` = 0 combinationally while `rst_n` is low.
  - Reset mid-transfer drops the word; no output valid appears at the edge where reset is sampled.
- **Latency**: a word accepted at edge N appears on `f[t]` with `v[t]`=1 after edge N.
- **Throughput**
  - One word per cycle sustained into a channel whose ready stays 1.
  - Round-robin mode sustains one word per cycle when all readies are 1.
- **Drain timing**: the consumer takes the word at the edge where `vk & rk` is sampled. `vk` falls after that edge unless the channel is reloaded.
- **Combinational paths**: `in_ready` depends on `r[t]`, `s`, `mode`, `rst_n`. There is no combinational path from `w` to any output.

## Test plan
- **Reset**
  - Stimulus: hold `rst_n`=0 for 2 cycles with `in_valid`=1, `w`=4'd9.
  - Required: all `fk`=0, all `vk`=0, `in_ready`=0, `ptr`=0; after release, no channel is valid until the first accept.
- **Explicit select**
  - Stimulus: `mode`=0, all `rk`=0; send 3 (`s`=0), 5 (`s`=1), 7 (`s`=2), 11 (`s`=3) on consecutive cycles.
  - Required: `f0`=3, `f1`=5, `f2`=7, `f3`=11, all `vk`=1.
  - Stimulus: then send 2 with `s`=0.
  - Required: `in_ready`=0 and `f0` remains 3.
- **Drain and reload**
  - Stimulus: `v1`=1 holding 5; assert `r1`=1 and send 4 with `s`=1 in the same cycle.
  - Required: after the edge, `f1`=4 and `v1`=1.
  - Stimulus: next cycle no input, `r1`=1.
  - Required: `v1`=0 and `f1` stays 4.
- **Round-robin wrap**
  - Stimulus: `mode`=1, all `rk`=1; send 2, 4, 6, 10, 12 back-to-back.
  - Required: the words land on channels 0, 1, 2, 3, 0 respectively; `ptr`=1 at the end; `in_ready`=1 every cycle.
- **Round-robin stall**
  - Stimulus: `mode`=1, `ptr`=2, `v2`=1, `r2`=0.
  - Required: `in_ready`=0 and `ptr` holds at 2.
  - Stimulus: set `r2`=1.
  - Required: the word is accepted and `ptr` becomes 3.
- **Reset mid-operation**
  - Stimulus: with `v0`..`v3`=1 and an input pending, pull `rst_n` low for 1 cycle.
  - Required: all `vk`=0, all `fk`=0, `ptr`=0; the pending word is not delivered.
